rpn_lan_tx: RTL and testbench



---
 rtl/rpn_lan_tx.sv | 208 ++++++++++++++++++++
 tb/tb_rpn_lan_tx.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rpn_lan_tx.sv
// Reliable LAN transmitter: stamps control messages with per-destination sequence numbers,
// sends them over KnownIP, retries on ACK timeout. Optional recovery via RPN_LAN_TX_SEQ_CHECK_EN.
module rpn_lan_tx #(
  parameter int NODE_ID_WIDTH   = 8,
  parameter int SEQ_WIDTH       = 32,
  parameter int PAYLOAD_WIDTH   = 448,
  parameter int AXIS_DATA_WIDTH = 512,
  parameter int AXIS_KEEP_WIDTH = 64,
  parameter int BRAM_ADDR_WIDTH = 32,
  parameter int TIMEOUT_CYCLES  = 1024,
  parameter int MAX_RETRIES     = 3,
  parameter logic [7:0] MSG_LAN_DATA          = 8'h01,
  parameter logic [7:0] MSG_LAN_ACK           = 8'h02,
  parameter logic [7:0] MSG_LAN_SEQ_NUM_CHECK = 8'h03,
  parameter logic [7:0] MSG_LAN_SEQ_NUM_REPLY = 8'h04
) (
  input  logic                       i_clk,
  input  logic                       i_ap_rst_n,
  input  logic [NODE_ID_WIDTH-1:0]   i_node_id,
  input  logic [15:0]                i_KIP_port_number,
  input  logic                       from_ctrl_tvalid,
  output logic                       from_ctrl_tready,
  input  logic [PAYLOAD_WIDTH-1:0]   from_ctrl_tdata,
  input  logic [NODE_ID_WIDTH-1:0]   from_ctrl_tdest,
  input  logic [31:0]                from_ctrl_tuser,
  output logic                       to_nb_KIP_tvalid,
  input  logic                       to_nb_KIP_tready,
  output logic [AXIS_DATA_WIDTH-1:0] to_nb_KIP_tdata,
  output logic [AXIS_KEEP_WIDTH-1:0] to_nb_KIP_tkeep,
  output logic [63:0]                to_nb_KIP_tuser,
  output logic                       to_nb_KIP_tlast,
  input  logic                       from_ack_tvalid,
  output logic                       from_ack_tready,
  input  logic [AXIS_DATA_WIDTH-1:0] from_ack_tdata,
  output logic                       to_seq_BRAM_CLK,
  output logic                       to_seq_BRAM_RST,
  output logic                       to_seq_BRAM_EN,
  output logic [3:0]                 to_seq_BRAM_WEN,
  output logic [BRAM_ADDR_WIDTH-1:0] to_seq_BRAM_ADDR,
  output logic [SEQ_WIDTH-1:0]       to_seq_BRAM_DIN,
  input  logic [SEQ_WIDTH-1:0]       to_seq_BRAM_DOUT,
  output logic                       o_tx_fail
);

  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int RW = $clog2(MAX_RETRIES + 1) + 1;

  typedef enum logic [2:0] {
    IDLE,
    READ_SEQ,
    SEND,
    WAIT_ACK,
`ifdef RPN_LAN_TX_SEQ_CHECK_EN
    SEND_CHECK,
    WAIT_REPLY,
`endif
    WRITE_SEQ
  } state_t;

  state_t                   state_q;
  logic [PAYLOAD_WIDTH-1:0] payload_q;
  logic [NODE_ID_WIDTH-1:0] dest_q;
  logic [31:0]              ip_q;
  logic [SEQ_WIDTH-1:0]     seq_q;
  logic [RW-1:0]            retry_q;
  logic [TW-1:0]            timer_q;
  logic                     fail_q;

  logic [7:0]               ackType;
  logic [NODE_ID_WIDTH-1:0] ackNode;
  logic [SEQ_WIDTH-1:0]     ackSeq;
  logic                     ackFromDest;
  logic                     ackMatch;
  logic                     timeout;
  logic                     retriesLeft;
  logic [7:0]               msgType;
  logic [NODE_ID_WIDTH-1:0] addrNode;
  logic                     unusedBits;

  assign ackType     = from_ack_tdata[7:0];
  assign ackNode     = from_ack_tdata[8 +: NODE_ID_WIDTH];
  assign ackSeq      = from_ack_tdata[16 +: SEQ_WIDTH];
  assign ackFromDest = from_ack_tvalid && (ackNode == dest_q);
  assign ackMatch    = ackFromDest && (ackType == MSG_LAN_ACK) && (ackSeq == seq_q);
  assign timeout     = (timer_q == TW'(TIMEOUT_CYCLES - 1));
  assign retriesLeft = (retry_q < RW'(MAX_RETRIES));
  assign unusedBits  = ^{from_ack_tdata[AXIS_DATA_WIDTH-1:16+SEQ_WIDTH],
                         MSG_LAN_SEQ_NUM_CHECK, MSG_LAN_SEQ_NUM_REPLY};

  always_ff @(posedge i_clk or negedge i_ap_rst_n) begin
    if (!i_ap_rst_n) begin
      state_q   <= IDLE;
      payload_q <= '0;
      dest_q    <= '0;
      ip_q      <= '0;
      seq_q     <= '0;
      retry_q   <= '0;
      timer_q   <= '0;
      fail_q    <= 1'b0;
    end else begin
      fail_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (from_ctrl_tvalid) begin
            payload_q <= from_ctrl_tdata;
            dest_q    <= from_ctrl_tdest;
            ip_q      <= from_ctrl_tuser;
            state_q   <= READ_SEQ;
          end
        end
        READ_SEQ: begin
          seq_q   <= to_seq_BRAM_DOUT + SEQ_WIDTH'(1);
          retry_q <= '0;
          timer_q <= '0;
          state_q <= SEND;
        end
        SEND: begin
          if (to_nb_KIP_tready) begin
            timer_q <= '0;
            state_q <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          // A match on the timeout cycle still wins over the retry.
          if (ackMatch) begin
            state_q <= WRITE_SEQ;
          end else if (timeout) begin
            if (retriesLeft) begin
              retry_q <= retry_q + RW'(1);
              state_q <= SEND;
            end else begin
`ifdef RPN_LAN_TX_SEQ_CHECK_EN
              state_q <= SEND_CHECK;
`else
              fail_q  <= 1'b1;
              state_q <= IDLE;
`endif
            end
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
`ifdef RPN_LAN_TX_SEQ_CHECK_EN
        SEND_CHECK: begin
          if (to_nb_KIP_tready) begin
            timer_q <= '0;
            state_q <= WAIT_REPLY;
          end
        end
        WAIT_REPLY: begin
          // Reply seq equal to ours means the data arrived but its ACK was lost.
          if (ackFromDest && (ackType == MSG_LAN_SEQ_NUM_REPLY)) begin
            if (ackSeq == seq_q) begin
              state_q <= WRITE_SEQ;
            end else if (ackSeq == seq_q - SEQ_WIDTH'(1)) begin
              retry_q <= '0;
              state_q <= SEND;
            end else begin
              fail_q  <= 1'b1;
              state_q <= IDLE;
            end
          end else if (timeout) begin
            fail_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
`endif
        WRITE_SEQ: state_q <= IDLE;
        default:   state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    to_nb_KIP_tvalid = 1'b0;
    msgType          = MSG_LAN_DATA;
    if (state_q == SEND) begin
      to_nb_KIP_tvalid = 1'b1;
    end
`ifdef RPN_LAN_TX_SEQ_CHECK_EN
    if (state_q == SEND_CHECK) begin
      to_nb_KIP_tvalid = 1'b1;
      msgType          = MSG_LAN_SEQ_NUM_CHECK;
    end
`endif
  end

  assign from_ctrl_tready = (state_q == IDLE);
  assign from_ack_tready  = 1'b1;

  assign to_nb_KIP_tdata = AXIS_DATA_WIDTH'({payload_q, 16'h0000, seq_q, i_node_id, msgType});
  assign to_nb_KIP_tkeep = '1;
  assign to_nb_KIP_tuser = {i_KIP_port_number, i_KIP_port_number, ip_q};
  assign to_nb_KIP_tlast = 1'b1;

  // The read is issued straight from IDLE so DOUT is ready in READ_SEQ.
  assign addrNode         = (state_q == IDLE) ? from_ctrl_tdest : dest_q;
  assign to_seq_BRAM_CLK  = i_clk;
  assign to_seq_BRAM_RST  = ~i_ap_rst_n;
  assign to_seq_BRAM_EN   = ((state_q == IDLE) && from_ctrl_tvalid) || (state_q == WRITE_SEQ);
  assign to_seq_BRAM_WEN  = (state_q == WRITE_SEQ) ? 4'hF : 4'h0;
  assign to_seq_BRAM_ADDR = BRAM_ADDR_WIDTH'({addrNode, 2'b00});
  assign to_seq_BRAM_DIN  = seq_q;
  assign o_tx_fail        = fail_q;

endmodule

// File: tb/tb_rpn_lan_tx.sv
// Directed testbench for rpn_lan_tx with a behavioural sequence BRAM and a KnownIP/ACK monitor.
module tb_rpn_lan_tx;

  localparam int TO = 64;
  localparam logic [7:0]  NODE = 8'h2A;
  localparam logic [15:0] PORT = 16'h1234;

  logic         i_clk;
  logic         i_ap_rst_n;
  logic [7:0]   i_node_id;
  logic [15:0]  i_KIP_port_number;
  logic         from_ctrl_tvalid;
  logic         from_ctrl_tready;
  logic [447:0] from_ctrl_tdata;
  logic [7:0]   from_ctrl_tdest;
  logic [31:0]  from_ctrl_tuser;
  logic         to_nb_KIP_tvalid;
  logic         to_nb_KIP_tready;
  logic [511:0] to_nb_KIP_tdata;
  logic [63:0]  to_nb_KIP_tkeep;
  logic [63:0]  to_nb_KIP_tuser;
  logic         to_nb_KIP_tlast;
  logic         from_ack_tvalid;
  logic         from_ack_tready;
  logic [511:0] from_ack_tdata;
  logic         to_seq_BRAM_CLK;
  logic         to_seq_BRAM_RST;
  logic         to_seq_BRAM_EN;
  logic [3:0]   to_seq_BRAM_WEN;
  logic [31:0]  to_seq_BRAM_ADDR;
  logic [31:0]  to_seq_BRAM_DIN;
  logic [31:0]  to_seq_BRAM_DOUT;
  logic         o_tx_fail;

  rpn_lan_tx #(.TIMEOUT_CYCLES(TO)) dut (
    .i_clk(i_clk), .i_ap_rst_n(i_ap_rst_n), .i_node_id(i_node_id),
    .i_KIP_port_number(i_KIP_port_number),
    .from_ctrl_tvalid(from_ctrl_tvalid), .from_ctrl_tready(from_ctrl_tready),
    .from_ctrl_tdata(from_ctrl_tdata), .from_ctrl_tdest(from_ctrl_tdest),
    .from_ctrl_tuser(from_ctrl_tuser),
    .to_nb_KIP_tvalid(to_nb_KIP_tvalid), .to_nb_KIP_tready(to_nb_KIP_tready),
    .to_nb_KIP_tdata(to_nb_KIP_tdata), .to_nb_KIP_tkeep(to_nb_KIP_tkeep),
    .to_nb_KIP_tuser(to_nb_KIP_tuser), .to_nb_KIP_tlast(to_nb_KIP_tlast),
    .from_ack_tvalid(from_ack_tvalid), .from_ack_tready(from_ack_tready),
    .from_ack_tdata(from_ack_tdata),
    .to_seq_BRAM_CLK(to_seq_BRAM_CLK), .to_seq_BRAM_RST(to_seq_BRAM_RST),
    .to_seq_BRAM_EN(to_seq_BRAM_EN), .to_seq_BRAM_WEN(to_seq_BRAM_WEN),
    .to_seq_BRAM_ADDR(to_seq_BRAM_ADDR), .to_seq_BRAM_DIN(to_seq_BRAM_DIN),
    .to_seq_BRAM_DOUT(to_seq_BRAM_DOUT), .o_tx_fail(o_tx_fail)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge i_clk) cyc <= cyc + 1;

  // Sequence BRAM model with one-cycle read latency; preset lets the bench seed an entry.
  logic [31:0] mem [0:255];
  logic        memClear;
  logic        presetEn;
  logic [7:0]  presetIdx;
  logic [31:0] presetVal;

  always @(posedge i_clk) begin
    if (memClear) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else if (presetEn) begin
      mem[presetIdx] <= presetVal;
    end else if (to_seq_BRAM_EN) begin
      if (to_seq_BRAM_WEN == 4'hF) mem[to_seq_BRAM_ADDR[9:2]] <= to_seq_BRAM_DIN;
      to_seq_BRAM_DOUT <= mem[to_seq_BRAM_ADDR[9:2]];
    end
  end

  // Monitor sampled on the falling edge, between input changes and the next active edge.
  int           dataBeats = 0;
  int           checkBeats = 0;
  int           bramWrites = 0;
  int           failHigh = 0;
  int           lastDataCyc = 0;
  int           acceptCyc = 0;
  int           firstValidCyc = 0;
  logic         prevTvalid = 1'b0;
  logic [511:0] lastData = '0;
  logic [63:0]  lastUser = '0;
  logic [63:0]  lastKeep = '0;
  logic         lastLast = 1'b0;
  logic [31:0]  lastCheckSeq = '0;
  logic [31:0]  lastWrAddr = '0;
  logic [31:0]  lastWrData = '0;

  always @(negedge i_clk) begin
    if (to_nb_KIP_tvalid && to_nb_KIP_tready) begin
      if (to_nb_KIP_tdata[7:0] == 8'h01) begin
        dataBeats++;
        lastDataCyc = cyc;
        lastData = to_nb_KIP_tdata;
        lastUser = to_nb_KIP_tuser;
        lastKeep = to_nb_KIP_tkeep;
        lastLast = to_nb_KIP_tlast;
      end else if (to_nb_KIP_tdata[7:0] == 8'h03) begin
        checkBeats++;
        lastCheckSeq = to_nb_KIP_tdata[47:16];
      end
    end
    if (to_seq_BRAM_EN && to_seq_BRAM_WEN == 4'hF) begin
      bramWrites++;
      lastWrAddr = to_seq_BRAM_ADDR;
      lastWrData = to_seq_BRAM_DIN;
    end
    if (o_tx_fail) failHigh++;
    if (from_ctrl_tvalid && from_ctrl_tready) acceptCyc = cyc;
    if (to_nb_KIP_tvalid && !prevTvalid) firstValidCyc = cyc;
    prevTvalid = to_nb_KIP_tvalid;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] dest, input logic [447:0] payload, input logic [31:0] ip);
    int n;
    tick(1);
    from_ctrl_tvalid = 1'b1;
    from_ctrl_tdest  = dest;
    from_ctrl_tdata  = payload;
    from_ctrl_tuser  = ip;
    n = 0;
    while (!from_ctrl_tready && n < 2000) begin
      tick(1);
      n++;
    end
    checkOutput("ctrl_accept", {63'd0, from_ctrl_tready}, 64'd1);
    tick(1);
    from_ctrl_tvalid = 1'b0;
  endtask

  task automatic sendAck(input logic [7:0] kind, input logic [7:0] node, input logic [31:0] seq);
    from_ack_tvalid       = 1'b1;
    from_ack_tdata        = '0;
    from_ack_tdata[7:0]   = kind;
    from_ack_tdata[15:8]  = node;
    from_ack_tdata[47:16] = seq;
    tick(1);
    from_ack_tvalid = 1'b0;
    from_ack_tdata  = '0;
  endtask

  task automatic waitData(input string tag, input int target, input int limit);
    int n = 0;
    while (dataBeats < target && n < limit) begin
      tick(1);
      n++;
    end
    checkOutput(tag, 64'(dataBeats), 64'(target));
  endtask

  task automatic waitWrites(input string tag, input int target, input int limit);
    int n = 0;
    while (bramWrites < target && n < limit) begin
      tick(1);
      n++;
    end
    checkOutput(tag, 64'(bramWrites), 64'(target));
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  logic [447:0] pay;
  logic [511:0] snap;
  logic         stableOk;
  int           s;
  int           s0;

  initial begin
    i_ap_rst_n        = 1'b0;
    i_node_id         = NODE;
    i_KIP_port_number = PORT;
    from_ctrl_tvalid  = 1'b0;
    from_ctrl_tdata   = '0;
    from_ctrl_tdest   = '0;
    from_ctrl_tuser   = '0;
    to_nb_KIP_tready  = 1'b1;
    from_ack_tvalid   = 1'b0;
    from_ack_tdata    = '0;
    memClear          = 1'b1;
    presetEn          = 1'b0;
    presetIdx         = '0;
    presetVal         = '0;

    tick(3);
    checkOutput("rst_tvalid", {63'd0, to_nb_KIP_tvalid}, 64'd0);
    checkOutput("rst_bram_en", {63'd0, to_seq_BRAM_EN}, 64'd0);
    checkOutput("rst_bram_wen", {60'd0, to_seq_BRAM_WEN}, 64'd0);
    checkOutput("rst_fail", {63'd0, o_tx_fail}, 64'd0);
    checkOutput("rst_bram_rst", {63'd0, to_seq_BRAM_RST}, 64'd1);
    memClear   = 1'b0;
    i_ap_rst_n = 1'b1;
    #1;
    checkOutput("rst_ctrl_ready", {63'd0, from_ctrl_tready}, 64'd1);
    checkOutput("rst_ack_ready", {63'd0, from_ack_tready}, 64'd1);

    // Fresh node 5, ACK ten cycles after the send.
    pay = {14{32'hC0DE0000 | 32'(cyc)}};
    pay[31:0] = 32'hDEADBEEF;
    applyStimulus(8'd5, pay, 32'h0A000005);
    waitData("t1_data_beat", 1, 20);
    checkOutput("t1_latency", 64'(firstValidCyc - acceptCyc), 64'd2);
    checkOutput("t1_type", {56'd0, lastData[7:0]}, 64'h01);
    checkOutput("t1_sender", {56'd0, lastData[15:8]}, {56'd0, NODE});
    checkOutput("t1_seq", {32'd0, lastData[47:16]}, 64'd1);
    checkOutput("t1_pad", {48'd0, lastData[63:48]}, 64'd0);
    checkOutput("t1_payload", {63'd0, lastData[511:64] == pay}, 64'd1);
    checkOutput("t1_tuser", lastUser, {PORT, PORT, 32'h0A000005});
    checkOutput("t1_tkeep", lastKeep, 64'hFFFF_FFFF_FFFF_FFFF);
    checkOutput("t1_tlast", {63'd0, lastLast}, 64'd1);
    tick(9);
    sendAck(8'h02, 8'd5, 32'd1);
    waitWrites("t1_write", 1, 10);
    checkOutput("t1_wr_addr", {32'd0, lastWrAddr}, 64'h14);
    checkOutput("t1_wr_data", {32'd0, lastWrData}, 64'd1);
    tick(5);
    checkOutput("t1_no_resend", 64'(dataBeats), 64'd1);

    // Sequence wrap: stored 0xFFFFFFFF yields seq 0, zero-latency ACK.
    presetEn = 1'b1; presetIdx = 8'd5; presetVal = 32'hFFFF_FFFF;
    tick(1);
    presetEn = 1'b0;
    applyStimulus(8'd5, {14{32'h11112222}}, 32'h0A000005);
    waitData("t2_data_beat", 2, 20);
    checkOutput("t2_seq", {32'd0, lastData[47:16]}, 64'd0);
    sendAck(8'h02, 8'd5, 32'd0);
    waitWrites("t2_write", 2, 10);
    checkOutput("t2_wr_data", {32'd0, lastWrData}, 64'd0);

    // Stray beats are dropped; a correct ACK on the timeout cycle beats the retry.
    applyStimulus(8'd7, {14{32'h33334444}}, 32'h0A000007);
    waitData("t3_data_beat", 3, 20);
    s = lastDataCyc;
    from_ack_tvalid = 1'b1;
    #1;
    checkOutput("t3_ack_ready", {63'd0, from_ack_tready}, 64'd1);
    sendAck(8'h02, 8'd8, 32'd1);
    sendAck(8'h02, 8'd7, 32'd2);
    sendAck(8'h02, 8'd7, 32'd0);
    sendAck(8'h04, 8'd7, 32'd1);
    checkOutput("t3_stray_no_write", 64'(bramWrites), 64'd2);
    while (cyc < s + TO) tick(1);
    sendAck(8'h02, 8'd7, 32'd1);
    waitWrites("t3_write", 3, 10);
    checkOutput("t3_wr_addr", {32'd0, lastWrAddr}, 64'h1C);
    tick(TO + 10);
    checkOutput("t3_no_resend", 64'(dataBeats), 64'd3);

    // Backpressure for 50 cycles, then no ACK at all.
    to_nb_KIP_tready = 1'b0;
    applyStimulus(8'd9, {14{32'h55556666}}, 32'h0A000009);
    tick(2);
    snap = to_nb_KIP_tdata;
    stableOk = to_nb_KIP_tvalid;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if (!to_nb_KIP_tvalid || to_nb_KIP_tdata !== snap) stableOk = 1'b0;
    end
    checkOutput("t4_hold_stable", {63'd0, stableOk}, 64'd1);
    to_nb_KIP_tready = 1'b1;
    waitData("t4_first_beat", 4, 5);
    s0 = lastDataCyc;
    waitData("t4_retry_beat", 5, TO + 20);
    checkOutput("t4_retry_gap", 64'(lastDataCyc - s0), 64'(TO + 1));
    waitData("t4_all_beats", 7, 3 * (TO + 20));
    checkOutput("t4_seq_kept", {32'd0, lastData[47:16]}, 64'd1);
`ifdef RPN_LAN_TX_SEQ_CHECK_EN
    s = 0;
    while (checkBeats < 1 && s < TO + 20) begin tick(1); s++; end
    checkOutput("t5_check_beat", 64'(checkBeats), 64'd1);
    checkOutput("t5_check_seq", {32'd0, lastCheckSeq}, 64'd1);
    sendAck(8'h04, 8'd9, 32'd1);
    waitWrites("t5_reply_write", 4, 10);
    checkOutput("t5_wr_addr", {32'd0, lastWrAddr}, 64'h24);
    checkOutput("t5_no_resend", 64'(dataBeats), 64'd7);

    applyStimulus(8'd10, {14{32'h77778888}}, 32'h0A00000A);
    waitData("t6_all_beats", 11, 4 * (TO + 20));
    s = 0;
    while (checkBeats < 2 && s < TO + 20) begin tick(1); s++; end
    checkOutput("t6_check_beat", 64'(checkBeats), 64'd2);
    sendAck(8'h04, 8'd10, 32'd0);
    waitData("t6_resend", 12, 10);
    checkOutput("t6_resend_seq", {32'd0, lastData[47:16]}, 64'd1);
    tick(2 * TO);
    checkOutput("t6_retries_cleared", 64'(dataBeats), 64'd13);
    sendAck(8'h02, 8'd10, 32'd1);
    waitWrites("t6_write", 5, 10);
    checkOutput("t6_wr_addr", {32'd0, lastWrAddr}, 64'h28);
    checkOutput("t6_no_fail", 64'(failHigh), 64'd0);
`else
    tick(TO + 10);
    checkOutput("t5_fail_pulse", 64'(failHigh), 64'd1);
    checkOutput("t5_no_write", 64'(bramWrites), 64'd3);
    checkOutput("t5_no_extra", 64'(dataBeats), 64'd7);

    applyStimulus(8'd9, {14{32'h9999AAAA}}, 32'h0A000009);
    waitData("t6_data_beat", 8, 20);
    checkOutput("t6_seq_reused", {32'd0, lastData[47:16]}, 64'd1);
    sendAck(8'h02, 8'd9, 32'd1);
    waitWrites("t6_write", 4, 10);
    checkOutput("t6_wr_addr", {32'd0, lastWrAddr}, 64'h24);
    checkOutput("t6_wr_data", {32'd0, lastWrData}, 64'd1);
`endif

    tick(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
